// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: keeps up to DEPTH word fetches in flight and buffers
// in-order responses in a show-ahead queue; redirect flushes and discards stale words.
module instr_prefetch #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [WORD_SIZE-1:0]  mem_resp_data,
    output logic                  instr_valid,
    output logic [WORD_SIZE-1:0]  instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  fetch_enable
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW:0] DepthW = DEPTH[CntW:0];

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [CntW-1:0]       outstanding_q, outstanding_d;
    logic [CntW-1:0]       discard_q, discard_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [WORD_SIZE-1:0]  data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [CntW:0]         credit_used;

    // Queued plus outstanding words never exceed DEPTH, so a push cannot overflow.
    assign credit_used   = {1'b0, count_q} + {1'b0, outstanding_q};
    assign mem_req_valid = rst_n && !redirect && (credit_used < DepthW);
    assign mem_addr      = fetch_pc_q;
    assign instr_valid   = (count_q != '0);
    assign instr         = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc      = instr_valid ? pc_mem[rd_ptr_q] : '0;
    assign accept        = mem_req_valid && mem_req_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        push          = 1'b0;
        pop           = 1'b0;
        if (redirect) begin
            fetch_pc_d    = redirect_addr;
            resp_pc_d     = redirect_addr;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            outstanding_d = outstanding_q - CntW'(mem_resp_valid);
            discard_d     = outstanding_d;
        end else begin
            pop = instr_valid && fetch_enable;
            if (mem_resp_valid) begin
                if (state_q == StDrain) begin
                    discard_d = discard_q - CntW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            outstanding_d = outstanding_q + CntW'(accept) - CntW'(mem_resp_valid);
            count_d       = count_q + CntW'(push) - CntW'(pop);
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR_WIDTH'(1);
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
        state_d = (discard_d != '0) ? StDrain : StRun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && pop) begin
            $display("ip = %d, instr = %h", instr_pc, instr);
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomised bench for instr_prefetch: a latency-modelled memory plus a queue-level
// reference model checked every cycle, with directed scenarios pinning key behaviour.
module tb_instr_prefetch;
    localparam int W = 16;
    localparam int AW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_resp_valid = 1'b0;
    logic [W-1:0]  mem_resp_data = '0;
    logic          instr_valid;
    logic [W-1:0]  instr;
    logic [AW-1:0] instr_pc;
    logic          fetch_enable = 1'b0;

    instr_prefetch #(
        .WORD_SIZE (W),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_enable  (fetch_enable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] pc;
    } entry_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    // Reference model state
    entry_t        mq[$];
    int            m_out;
    int            m_disc;
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_rpc;

    // Memory model state
    pend_t pq[$];
    int    last_due;
    int    cyc = 0;

    int vectors = 0;
    int errors = 0;

    int ready_pct = 100, fe_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
    bit force_redir = 0;
    bit force_ready_off = 0;
    logic [AW-1:0] force_addr = '0;

    int           hist_pc[$];
    int           hist_cyc[$];
    logic [W-1:0] hist_instr[$];
    int           acc_count;
    int           first_acc_addr;

    function automatic logic [W-1:0] data_of(input logic [AW-1:0] a);
        return a ^ 16'hA000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic hist_clear();
        hist_pc.delete();
        hist_cyc.delete();
        hist_instr.delete();
        acc_count = 0;
        first_acc_addr = -1;
    endtask

    task automatic step();
        logic          rv, red, rdy, fe, exp_rv;
        logic [W-1:0]  rd;
        logic [AW-1:0] raddr;
        int            due;
        @(negedge clk);
        red = force_redir || ($urandom_range(99) < redir_pct);
        raddr = AW'($urandom);
        if ($urandom_range(3) == 0) raddr = 16'hFFFC | AW'($urandom_range(3));
        if (force_redir) raddr = force_addr;
        rdy = !force_ready_off && ($urandom_range(99) < ready_pct);
        fe = $urandom_range(99) < fe_pct;
        rv = (pq.size() > 0) && (pq[0].due <= cyc);
        rd = rv ? data_of(pq[0].addr) : W'($urandom);
        redirect = red;
        redirect_addr = raddr;
        mem_req_ready = rdy;
        mem_resp_valid = rv;
        mem_resp_data = rd;
        fetch_enable = fe;
        #1;
        exp_rv = !red && ((mq.size() + m_out) < DEPTH);
        chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", 32'(mem_addr), 32'(m_fpc));
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("instr", 32'(instr), 32'(mq[0].data));
            chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
        end
        if (instr_valid) begin
            hist_pc.push_back(int'(instr_pc));
            hist_cyc.push_back(cyc);
            hist_instr.push_back(instr);
        end
        // Memory: in-order responses, one per cycle, at least one cycle after accept
        if (rv) void'(pq.pop_front());
        if (mem_req_valid && rdy) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            pq.push_back('{addr: mem_addr, due: due});
            last_due = due;
            if (first_acc_addr < 0) first_acc_addr = int'(mem_addr);
            acc_count++;
        end
        // Reference model
        if (red) begin
            mq.delete();
            m_disc = m_out - (rv ? 1 : 0);
            m_out = m_disc;
            m_fpc = raddr;
            m_rpc = raddr;
        end else begin
            if (fe && mq.size() > 0) void'(mq.pop_front());
            if (rv) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else begin
                    mq.push_back('{data: rd, pc: m_rpc});
                    m_rpc++;
                end
            end
            if (exp_rv && rdy) begin
                m_fpc++;
                m_out++;
            end
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        fetch_enable = 1'b0;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        mq.delete();
        pq.delete();
        m_out = 0;
        m_disc = 0;
        m_fpc = '0;
        m_rpc = '0;
        last_due = cyc;
        force_redir = 0;
        force_ready_off = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic knobs(input int rp, input int fp, input int dp, input int lmin, input int lmax);
        ready_pct = rp;
        fe_pct = fp;
        redir_pct = dp;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        int c0;
        // 1: streaming with 1-cycle memory
        do_reset();
        knobs(100, 100, 0, 1, 1);
        hist_clear();
        c0 = cyc;
        repeat (8) step();
        chk("t1_heads", 32'(hist_pc.size() >= 4), 32'd1);
        if (hist_pc.size() >= 4) begin
            chk("t1_first_cycle", 32'(hist_cyc[0]), 32'(c0 + 2));
            for (int i = 0; i < 4; i++) begin
                chk("t1_pc", 32'(hist_pc[i]), 32'(i));
                chk("t1_instr", 32'(hist_instr[i]), 32'h0000A000 + 32'(i));
                chk("t1_consec", 32'(hist_cyc[i]), 32'(c0 + 2 + i));
            end
        end

        // 2: consumer stalled, credit limit
        do_reset();
        knobs(100, 0, 0, 1, 1);
        hist_clear();
        repeat (10) step();
        #1;
        chk("t2_accepts", 32'(acc_count), 32'd4);
        chk("t2_req_off", 32'(mem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(instr_valid), 32'd1);
        chk("t2_head_pc", 32'(instr_pc), 32'd0);

        // 3: 3-cycle latency, redirect with 3 words in flight
        do_reset();
        knobs(100, 0, 0, 3, 3);
        repeat (3) step();
        force_ready_off = 1;
        force_redir = 1;
        force_addr = 16'h0040;
        step();
        force_redir = 0;
        force_ready_off = 0;
        knobs(100, 100, 0, 3, 3);
        hist_clear();
        repeat (12) step();
        chk("t3_heads", 32'(hist_pc.size() > 0), 32'd1);
        if (hist_pc.size() > 0) begin
            chk("t3_pc", 32'(hist_pc[0]), 32'h40);
            chk("t3_instr", 32'(hist_instr[0]), 32'(data_of(16'h0040)));
        end

        // 4: redirect coinciding with response and pop
        do_reset();
        knobs(100, 100, 0, 2, 2);
        repeat (3) step();
        force_redir = 1;
        force_addr = 16'h1234;
        step();
        force_redir = 0;
        #1;
        chk("t4_empty", 32'(instr_valid), 32'd0);
        hist_clear();
        repeat (12) step();
        chk("t4_heads", 32'(hist_pc.size() > 0), 32'd1);
        if (hist_pc.size() > 0) chk("t4_pc", 32'(hist_pc[0]), 32'h1234);

        // 5: address wrap
        knobs(100, 100, 0, 1, 1);
        force_redir = 1;
        force_addr = 16'hFFFF;
        step();
        force_redir = 0;
        hist_clear();
        repeat (8) step();
        chk("t5_heads", 32'(hist_pc.size() >= 3), 32'd1);
        if (hist_pc.size() >= 3) begin
            chk("t5_pc0", 32'(hist_pc[0]), 32'hFFFF);
            chk("t5_pc1", 32'(hist_pc[1]), 32'h0000);
            chk("t5_pc2", 32'(hist_pc[2]), 32'h0001);
        end

        // 6: reset mid-stream with 2 outstanding
        do_reset();
        knobs(100, 100, 0, 3, 3);
        repeat (2) step();
        do_reset();
        hist_clear();
        repeat (10) step();
        chk("t6_restart_addr", 32'(first_acc_addr), 32'd0);
        chk("t6_heads", 32'(hist_pc.size() > 0), 32'd1);
        if (hist_pc.size() > 0) chk("t6_pc", 32'(hist_pc[0]), 32'd0);

        // Randomised phases
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(7) == 0) do_reset();
            knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 0)),
                  int'($urandom_range(10, 0)), 1, int'($urandom_range(5, 1)));
            repeat (100) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
